// File: rtl/latch_bank.sv
// Multi-channel storage bank: per-write LATCH/EDGE/TOGGLE/HOLD modes, a sequenced
// bulk clear that sweeps one channel per cycle, and a saturating change counter.
module latch_bank #(
    parameter int WIDTH    = 8,
    parameter int CHANNELS = 4,
    parameter int CNT_W    = 8
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          ena,
    input  logic [WIDTH-1:0]              d_in,
    input  logic                          gate,
    input  logic [1:0]                    mode,
    input  logic [$clog2(CHANNELS)-1:0]   wr_addr,
    input  logic                          clr_req,
    input  logic [$clog2(CHANNELS)-1:0]   rd_addr,
    output logic [WIDTH-1:0]              rd_data,
    output logic [CNT_W-1:0]              change_cnt,
    output logic                          busy
);
    localparam int AW = $clog2(CHANNELS);

    typedef enum logic {
        IDLE,
        CLEAR
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] q_q [CHANNELS];
    logic [WIDTH-1:0] q_d [CHANNELS];
    logic [AW-1:0]    idx_q, idx_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             gate_q;
    logic             busy_q, busy_d;

    logic             rise;
    logic             wr_ok;
    logic             wr_en;
    logic [WIDTH-1:0] old_val;
    logic [WIDTH-1:0] new_val;

    assign rise  = gate & ~gate_q;
    // Address compared one bit wider so a CHANNELS that fills AW bits never aliases to zero.
    assign wr_ok = {1'b0, wr_addr} < (AW+1)'(CHANNELS);

    always_comb begin
        old_val = '0;
        for (int unsigned i = 0; i < CHANNELS; i++) begin
            if (wr_addr == AW'(i)) old_val = q_q[i];
        end
    end

    always_comb begin
        rd_data = '0;
        for (int unsigned i = 0; i < CHANNELS; i++) begin
            if (rd_addr == AW'(i)) rd_data = q_q[i];
        end
    end

    always_comb begin
        wr_en   = 1'b0;
        new_val = d_in;
        case (mode)
            2'b00:   wr_en = gate;
            2'b01:   wr_en = rise;
            2'b10: begin
                wr_en   = rise;
                new_val = old_val ^ d_in;
            end
            default: wr_en = 1'b0;
        endcase
        wr_en = wr_en & wr_ok;
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        q_d     = q_q;
        if (ena) begin
            case (state_q)
                IDLE: begin
                    if (clr_req) begin
                        state_d = CLEAR;
                        idx_d   = '0;
                        cnt_d   = '0;
                    end else if (wr_en) begin
                        for (int unsigned i = 0; i < CHANNELS; i++) begin
                            if (wr_addr == AW'(i)) q_d[i] = new_val;
                        end
                        if (new_val != old_val && cnt_q != '1) cnt_d = cnt_q + 1'b1;
                    end
                end
                CLEAR: begin
                    for (int unsigned i = 0; i < CHANNELS; i++) begin
                        if (idx_q == AW'(i)) q_d[i] = '0;
                    end
                    if (idx_q == AW'(CHANNELS - 1)) begin
                        state_d = IDLE;
                        idx_d   = '0;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
        busy_d = (state_d == CLEAR);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q_q     <= '{default: '0};
            state_q <= IDLE;
            idx_q   <= '0;
            cnt_q   <= '0;
            gate_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            q_q     <= q_d;
            state_q <= state_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            gate_q  <= gate;
            busy_q  <= busy_d;
        end
    end

    assign change_cnt = cnt_q;
    assign busy       = busy_q;

endmodule

// File: tb/tb_latch_bank.sv
// Bench for latch_bank: a 4-channel/8-bit-counter and a 3-channel/2-bit-counter
// instance share one stimulus stream and are compared against a behavioural model.
module tb_latch_bank;
    logic       clk = 1'b0;
    logic       rst, ena, gate, clr_req;
    logic [7:0] d_in;
    logic [1:0] mode, wr_addr, rd_addr;
    logic [7:0] rd_a, rd_b;
    logic [7:0] cnt_a;
    logic [1:0] cnt_b;
    logic       busy_a, busy_b;

    int unsigned n_vec = 0;
    int unsigned n_bad = 0;

    // model state: index 0 = 4-channel instance, 1 = 3-channel instance
    int mq   [2][4];
    int mcnt [2];
    bit mclr [2];
    int mpos [2];
    bit mprev;

    always #5 clk = ~clk;

    latch_bank #(.WIDTH(8), .CHANNELS(4), .CNT_W(8)) u_a (
        .clk(clk), .rst(rst), .ena(ena), .d_in(d_in), .gate(gate), .mode(mode),
        .wr_addr(wr_addr), .clr_req(clr_req), .rd_addr(rd_addr),
        .rd_data(rd_a), .change_cnt(cnt_a), .busy(busy_a)
    );

    latch_bank #(.WIDTH(8), .CHANNELS(3), .CNT_W(2)) u_b (
        .clk(clk), .rst(rst), .ena(ena), .d_in(d_in), .gate(gate), .mode(mode),
        .wr_addr(wr_addr), .clr_req(clr_req), .rd_addr(rd_addr),
        .rd_data(rd_b), .change_cnt(cnt_b), .busy(busy_b)
    );

    function automatic int nch(input int m);
        return (m == 0) ? 4 : 3;
    endfunction

    function automatic int cmax(input int m);
        return (m == 0) ? 255 : 3;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int m = 0; m < 2; m++) begin
            for (int c = 0; c < 4; c++) mq[m][c] = 0;
            mcnt[m] = 0;
            mclr[m] = 1'b0;
            mpos[m] = 0;
        end
        mprev = 1'b0;
    endtask

    task automatic model_step();
        bit rise;
        bit we;
        int nv;
        rise  = gate && !mprev;
        mprev = gate;
        for (int m = 0; m < 2; m++) begin
            if (ena) begin
                if (mclr[m]) begin
                    mq[m][mpos[m]] = 0;
                    mpos[m]++;
                    if (mpos[m] == nch(m)) mclr[m] = 1'b0;
                end else if (clr_req) begin
                    mclr[m] = 1'b1;
                    mpos[m] = 0;
                    mcnt[m] = 0;
                end else if (int'(wr_addr) < nch(m)) begin
                    we = 1'b0;
                    nv = 0;
                    case (mode)
                        2'd0: begin we = gate; nv = int'(d_in); end
                        2'd1: begin we = rise; nv = int'(d_in); end
                        2'd2: begin we = rise; nv = mq[m][wr_addr] ^ int'(d_in); end
                        default: we = 1'b0;
                    endcase
                    if (we && nv != mq[m][wr_addr]) begin
                        mq[m][wr_addr] = nv;
                        if (mcnt[m] < cmax(m)) mcnt[m]++;
                    end
                end
            end
        end
    endtask

    task automatic check_all();
        for (int r = 0; r < 4; r++) begin
            rd_addr = 2'(r);
            #1;
            chk("rd_a", 32'(rd_a), 32'(mq[0][r]));
            chk("rd_b", 32'(rd_b), (r < 3) ? 32'(mq[1][r]) : 32'd0);
        end
        chk("busy_a", 32'(busy_a), 32'(mclr[0]));
        chk("busy_b", 32'(busy_b), 32'(mclr[1]));
        chk("cnt_a", 32'(cnt_a), 32'(mcnt[0]));
        chk("cnt_b", 32'(cnt_b), 32'(mcnt[1]));
    endtask

    // inputs are changed only after this returns (posedge+5), well clear of the edge
    task automatic tick();
        @(posedge clk);
        if (rst) model_reset();
        else model_step();
        #1;
        check_all();
    endtask

    int n;

    initial begin
        rst = 1'b1; ena = 1'b0; gate = 1'b0; clr_req = 1'b0;
        d_in = '0; mode = '0; wr_addr = '0; rd_addr = '0;
        model_reset();
        tick();
        chk("rst_busy", 32'(busy_a), 32'd0);
        chk("rst_cnt", 32'(cnt_a), 32'd0);
        rst = 1'b0;
        ena = 1'b1;

        // LATCH
        mode = 2'd0; wr_addr = 2'd2; gate = 1'b1; d_in = 8'hA5;
        repeat (3) tick();
        gate = 1'b0; d_in = 8'h3C;
        tick();
        rd_addr = 2'd2; #1;
        chk("latch_val", 32'(rd_a), 32'h0A5);
        chk("latch_cnt", 32'(cnt_a), 32'd1);

        // EDGE
        mode = 2'd1; wr_addr = 2'd1; gate = 1'b1; d_in = 8'h11;
        tick();
        d_in = 8'h22; tick();
        rd_addr = 2'd1; #1;
        chk("edge_first", 32'(rd_a), 32'h011);
        gate = 1'b0; tick();
        gate = 1'b1; tick();
        rd_addr = 2'd1; #1;
        chk("edge_second", 32'(rd_a), 32'h022);
        chk("edge_cnt", 32'(cnt_a), 32'd3);
        gate = 1'b0; tick();

        // TOGGLE
        mode = 2'd0; wr_addr = 2'd0; gate = 1'b1; d_in = 8'h0F; tick();
        gate = 1'b0; tick();
        mode = 2'd2; d_in = 8'hFF;
        gate = 1'b1; tick();
        rd_addr = 2'd0; #1;
        chk("tog_1", 32'(rd_a), 32'h0F0);
        gate = 1'b0; tick();
        gate = 1'b1; tick();
        gate = 1'b0; tick();
        d_in = 8'h00; gate = 1'b1; tick();
        rd_addr = 2'd0; #1;
        chk("tog_3", 32'(rd_a), 32'h00F);
        chk("tog_cnt", 32'(cnt_a), 32'd6);
        chk("sat_cnt_b", 32'(cnt_b), 32'd3);
        gate = 1'b0; tick();

        // out-of-range write on the 3-channel instance
        mode = 2'd0; wr_addr = 2'd3; gate = 1'b1; d_in = 8'h77; tick();
        rd_addr = 2'd3; #1;
        chk("range_rd_b", 32'(rd_b), 32'd0);
        chk("range_rd_a", 32'(rd_a), 32'h077);
        gate = 1'b0; tick();

        // clear with a simultaneous gate rise
        clr_req = 1'b1; mode = 2'd1; gate = 1'b1; wr_addr = 2'd3; d_in = 8'h55;
        tick();
        n = busy_a ? 1 : 0;
        clr_req = 1'b0;
        for (int i = 0; i < 10; i++) begin
            gate = 1'($urandom);
            tick();
            if (busy_a) n++;
            else break;
        end
        chk("clr_len", 32'(n), 32'd4);
        rd_addr = 2'd3; #1;
        chk("clr_drop", 32'(rd_a), 32'd0);
        chk("clr_cnt", 32'(cnt_a), 32'd0);
        gate = 1'b0; tick();

        // clear stretched by two disabled cycles
        clr_req = 1'b1; tick();
        n = busy_a ? 1 : 0;
        clr_req = 1'b0;
        for (int i = 0; i < 20; i++) begin
            ena = !(i == 1 || i == 2);
            tick();
            if (busy_a) n++;
            else break;
        end
        ena = 1'b1;
        chk("clr_ena_len", 32'(n), 32'd6);

        // async reset in the middle of a clear
        mode = 2'd0; wr_addr = 2'd1; gate = 1'b1; d_in = 8'h5A; tick();
        gate = 1'b0; clr_req = 1'b1; tick();
        clr_req = 1'b0; tick();
        rd_addr = 2'd1;
        #2;
        rst = 1'b1;
        #1;
        chk("arst_busy", 32'(busy_a), 32'd0);
        chk("arst_busy_b", 32'(busy_b), 32'd0);
        chk("arst_rd", 32'(rd_a), 32'd0);
        chk("arst_cnt", 32'(cnt_a), 32'd0);
        model_reset();
        tick();
        rst = 1'b0;

        // randomized traffic
        for (int i = 0; i < 800; i++) begin
            ena     = ($urandom_range(7) != 0);
            gate    = 1'($urandom);
            mode    = 2'($urandom);
            wr_addr = 2'($urandom);
            d_in    = ($urandom_range(3) == 0) ? 8'h00 : 8'($urandom);
            clr_req = ($urandom_range(39) == 0);
            rst     = ($urandom_range(299) == 0);
            tick();
        end
        rst = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
